spi_reg_ctrl: RTL and testbench

//   Register-access protocol engine, downstream of the Mode-0 SPI slave. Snoops the same cs/mosi/sclk,

---
 rtl/spi_reg_ctrl_if.sv | 33 +++
 rtl/spi_reg_ctrl.sv | 176 +++++++++++++++++
 tb/tb_spi_reg_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/spi_reg_ctrl_if.sv
//------------------------------------------------------------------------------
// Module     : spi_reg_ctrl_if
// Description: SPI snoop inputs and register-bank outputs of spi_reg_ctrl.
// Revision   : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface spi_reg_ctrl_if #(
    parameter int NUM_REGS   = 8,
    parameter int NUM_STATUS = 4
);
    logic                    cs;
    logic                    mosi;
    logic [NUM_STATUS*8-1:0] status_in;
    logic [NUM_REGS*8-1:0]   ctrl_out;
    logic                    wr_stb;
    logic [6:0]              wr_addr;
    logic [7:0]              wr_data;
    logic [7:0]              tx_data;
    logic                    err;

    modport slave (
        input  cs, mosi, status_in,
        output ctrl_out, wr_stb, wr_addr, wr_data, tx_data, err
    );

    modport master (
        output cs, mosi, status_in,
        input  ctrl_out, wr_stb, wr_addr, wr_data, tx_data, err
    );
endinterface

`default_nettype wire

// File: rtl/spi_reg_ctrl.sv
//------------------------------------------------------------------------------
// Module     : spi_reg_ctrl
// Description: SPI register-access engine; decodes cmd/data bytes into
//              control-register writes and read-back responses.
// Revision   : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module spi_reg_ctrl #(
    parameter int         NUM_REGS   = 8,
    parameter int         NUM_STATUS = 4,
    parameter logic [7:0] ID_VALUE   = 8'h5A
) (
    input  logic          sclk,
    input  logic          reset,
    spi_reg_ctrl_if.slave bus
);

    typedef enum logic [0:0] {
        ST_CMD  = 1'b0,
        ST_DATA = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic [6:0]            shift_q, shift_d;
    logic [6:0]            addr_q, addr_d;
    logic [7:0]            tx_q, tx_d;
    logic [NUM_REGS*8-1:0] ctrl_q, ctrl_d;
    logic                  wr_stb_q, wr_stb_d;
    logic [6:0]            wr_addr_q, wr_addr_d;
    logic [7:0]            wr_data_q, wr_data_d;
    logic                  err_q, err_d;

    logic       cs;
    logic       byte_done;
    logic [7:0] rx_byte;
    logic [7:0] rd_val;
    logic       rd_hit;
    logic       wr_hit;

    assign cs        = bus.cs;
    assign rx_byte   = {shift_q, bus.mosi};
    assign byte_done = ~cs & (bit_cnt_q == 3'd7);

    always_comb begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        shift_d   = rx_byte[6:0];
    end

    // Raising cs drops any partial byte without touching the protocol state.
    always_ff @(posedge sclk or posedge reset or posedge cs) begin
        if (reset) begin
            bit_cnt_q <= 3'd0;
            shift_q   <= 7'd0;
        end else if (cs) begin
            bit_cnt_q <= 3'd0;
            shift_q   <= 7'd0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
        end
    end

    // Read map, addressed by the low 7 bits of the byte completing this edge.
    always_comb begin
        rd_val = 8'h00;
        rd_hit = 1'b0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (rx_byte[6:0] == 7'(k)) begin
                rd_val = ctrl_q[8*k +: 8];
                rd_hit = 1'b1;
            end
        end
        for (int k = 0; k < NUM_STATUS; k++) begin
            if (rx_byte[6:0] == 7'(64 + k)) begin
                rd_val = bus.status_in[8*k +: 8];
                rd_hit = 1'b1;
            end
        end
        if (rx_byte[6:0] == 7'h7E) begin
            rd_val = {7'b0, err_q};
            rd_hit = 1'b1;
        end
        if (rx_byte[6:0] == 7'h7F) begin
            rd_val = ID_VALUE;
            rd_hit = 1'b1;
        end
    end

    always_comb begin
        wr_hit = 1'b0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (addr_q == 7'(k)) begin
                wr_hit = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        tx_d      = tx_q;
        ctrl_d    = ctrl_q;
        wr_stb_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        err_d     = err_q;
        if (byte_done) begin
            case (state_q)
                ST_CMD: begin
                    if (rx_byte[7]) begin
                        addr_d  = rx_byte[6:0];
                        state_d = ST_DATA;
                    end else begin
                        tx_d = rd_val;
                        if (!rd_hit) begin
                            err_d = 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    tx_d    = rx_byte;
                    state_d = ST_CMD;
                    if (wr_hit) begin
                        for (int k = 0; k < NUM_REGS; k++) begin
                            if (addr_q == 7'(k)) begin
                                ctrl_d[8*k +: 8] = rx_byte;
                            end
                        end
                        wr_stb_d  = 1'b1;
                        wr_addr_d = addr_q;
                        wr_data_d = rx_byte;
                    end else if (addr_q == 7'h7E) begin
                        err_d = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: state_d = ST_CMD;
            endcase
        end
    end

    always_ff @(posedge sclk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_CMD;
            addr_q    <= 7'd0;
            tx_q      <= 8'h00;
            ctrl_q    <= '0;
            wr_stb_q  <= 1'b0;
            wr_addr_q <= 7'd0;
            wr_data_q <= 8'h00;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            tx_q      <= tx_d;
            ctrl_q    <= ctrl_d;
            wr_stb_q  <= wr_stb_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            err_q     <= err_d;
        end
    end

    assign bus.ctrl_out = ctrl_q;
    assign bus.tx_data  = tx_q;
    assign bus.wr_stb   = wr_stb_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.err      = err_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_reg_ctrl.sv
//------------------------------------------------------------------------------
// Module     : tb_spi_reg_ctrl
// Description: Self-checking bench for spi_reg_ctrl (byte-level model + literals).
// Revision   : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_spi_reg_ctrl;
    localparam int NUM_REGS   = 8;
    localparam int NUM_STATUS = 4;

    logic sclk  = 1'b0;
    logic reset = 1'b0;

    spi_reg_ctrl_if #(.NUM_REGS(NUM_REGS), .NUM_STATUS(NUM_STATUS)) bus ();

    spi_reg_ctrl #(
        .NUM_REGS  (NUM_REGS),
        .NUM_STATUS(NUM_STATUS),
        .ID_VALUE  (8'h5A)
    ) dut (
        .sclk (sclk),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 sclk = ~sclk;

    // Reference model: transaction-level view of the register protocol.
    logic [7:0] m_regs [NUM_REGS];
    logic       m_err;
    logic [7:0] m_tx;
    logic [6:0] m_wr_addr;
    logic [7:0] m_wr_data;
    logic       m_stb;
    logic       m_in_data;
    logic [6:0] m_addr;
    int         m_bits;
    logic [7:0] m_byte;

    task automatic model_byte(input logic [7:0] b);
        int a;
        if (m_in_data) begin
            m_in_data = 1'b0;
            m_tx      = b;
            a         = int'(m_addr);
            if (a < NUM_REGS) begin
                m_regs[a] = b;
                m_stb     = 1'b1;
                m_wr_addr = m_addr;
                m_wr_data = b;
            end else if (a == 126) begin
                m_err = 1'b0;
            end else begin
                m_err = 1'b1;
            end
        end else if (b[7]) begin
            m_in_data = 1'b1;
            m_addr    = b[6:0];
        end else begin
            a = int'(b[6:0]);
            if (a < NUM_REGS)                        m_tx = m_regs[a];
            else if (a >= 64 && a < 64 + NUM_STATUS) m_tx = bus.status_in[8*(a-64) +: 8];
            else if (a == 126)                       m_tx = {7'b0, m_err};
            else if (a == 127)                       m_tx = 8'h5A;
            else begin
                m_tx  = 8'h00;
                m_err = 1'b1;
            end
        end
    endtask

    always @(posedge sclk or posedge reset or posedge bus.cs) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) m_regs[i] = 8'h00;
            m_err = 1'b0; m_tx = 8'h00; m_wr_addr = 7'd0; m_wr_data = 8'h00;
            m_stb = 1'b0; m_in_data = 1'b0; m_addr = 7'd0; m_bits = 0; m_byte = 8'h00;
        end else if (!sclk) begin
            m_bits = 0;
        end else begin
            m_stb = 1'b0;
            if (!bus.cs) begin
                m_byte = {m_byte[6:0], bus.mosi};
                m_bits++;
                if (m_bits == 8) begin
                    m_bits = 0;
                    model_byte(m_byte);
                end
            end
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic check_model();
        logic [63:0] e;
        if (!reset) begin
            e = '0;
            for (int i = 0; i < NUM_REGS; i++) e[8*i +: 8] = m_regs[i];
            chk("ctrl_out", 64'(bus.ctrl_out), e);
            chk("tx_data",  64'(bus.tx_data),  64'(m_tx));
            chk("err",      64'(bus.err),      64'(m_err));
            chk("wr_stb",   64'(bus.wr_stb),   64'(m_stb));
            chk("wr_addr",  64'(bus.wr_addr),  64'(m_wr_addr));
            chk("wr_data",  64'(bus.wr_data),  64'(m_wr_data));
        end
    endtask

    task automatic step();
        @(negedge sclk);
        check_model();
    endtask

    task automatic cs_low();
        step();
        bus.cs = 1'b0;
    endtask

    task automatic cs_high();
        bus.cs = 1'b1;
        step();
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            bus.mosi = b[7-i];
            step();
        end
    endtask

    task automatic frame1(input logic [7:0] b);
        cs_low();
        send_bits(b, 8);
        cs_high();
    endtask

    task automatic do_reset();
        @(negedge sclk);
        #2 reset = 1'b1;
        #10 reset = 1'b0;
        step();
    endtask

    initial begin
        bus.cs        = 1'b1;
        bus.mosi      = 1'b0;
        bus.status_in = '0;

        // 1: reset state and ID read
        do_reset();
        chk("rst_ctrl",   64'(bus.ctrl_out), 64'h0);
        chk("rst_tx",     64'(bus.tx_data),  64'h00);
        chk("rst_err",    64'(bus.err),      64'h0);
        chk("rst_wr_stb", 64'(bus.wr_stb),   64'h0);
        frame1(8'h7F);
        chk("id_read", 64'(bus.tx_data), 64'h5A);

        // 2: write reg3 in one cs window, then read it back
        cs_low();
        send_bits(8'h83, 8);
        send_bits(8'h3C, 8);
        chk("wr_stb_high", 64'(bus.wr_stb), 64'h1);
        cs_high();
        chk("wr_stb_low", 64'(bus.wr_stb),  64'h0);
        chk("reg3",       64'(bus.ctrl_out[31:24]), 64'h3C);
        chk("wr_addr",    64'(bus.wr_addr), 64'h03);
        chk("wr_data",    64'(bus.wr_data), 64'h3C);
        chk("echo",       64'(bus.tx_data), 64'h3C);
        frame1(8'h03);
        chk("read_reg3", 64'(bus.tx_data), 64'h3C);

        // 3: status read, write to read-only address
        bus.status_in = 32'h0000_9900;
        frame1(8'h41);
        chk("status1", 64'(bus.tx_data), 64'h99);
        cs_low();
        send_bits(8'hC1, 8);
        send_bits(8'h11, 8);
        chk("ro_no_stb", 64'(bus.wr_stb), 64'h0);
        cs_high();
        chk("ro_err",  64'(bus.err),      64'h1);
        chk("ro_ctrl", 64'(bus.ctrl_out), 64'h0000_0000_3C00_0000);

        // 4: error readback, clear, bad read sets it again
        frame1(8'h7E);
        chk("err_read", 64'(bus.tx_data), 64'h01);
        cs_low();
        send_bits(8'hFE, 8);
        send_bits(8'h00, 8);
        cs_high();
        chk("err_clr", 64'(bus.err), 64'h0);
        frame1(8'h20);
        chk("bad_rd_tx",  64'(bus.tx_data), 64'h00);
        chk("bad_rd_err", 64'(bus.err),     64'h1);

        // 5: partial byte discarded on cs rise
        cs_low();
        send_bits(8'h85, 5);
        cs_high();
        cs_low();
        send_bits(8'h85, 8);
        send_bits(8'h77, 8);
        cs_high();
        chk("partial_ctrl", 64'(bus.ctrl_out), 64'h0000_7700_3C00_0000);
        chk("partial_addr", 64'(bus.wr_addr),  64'h05);

        // 6: reset in the middle of a data byte
        cs_low();
        send_bits(8'h82, 8);
        send_bits(8'h55, 4);
        #2 reset = 1'b1;
        bus.cs = 1'b1;
        #10 reset = 1'b0;
        step();
        chk("mid_rst_ctrl", 64'(bus.ctrl_out), 64'h0);
        frame1(8'h02);
        chk("post_rst_ctrl", 64'(bus.ctrl_out), 64'h0);
        chk("post_rst_tx",   64'(bus.tx_data),  64'h00);
        chk("post_rst_err",  64'(bus.err),      64'h0);
        frame1(8'h7F);
        chk("post_rst_id",   64'(bus.tx_data),  64'h5A);

        step();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

`default_nettype wire
